// File: rtl/mos_strength_dec.sv
// Strength-symbol codeword decoder: frames St0/St1 symbols on sync, checks the
// alternating pattern and hands bit a out on valid/ready. Define
// MOS_STRENGTH_DEC_ERRCNT_EN to build the saturating error counter.
module mos_strength_dec #(
  parameter int SYMS  = 4,
  parameter int ERR_W = 8
) (
  input  logic             c,
  input  logic             rst,
  input  logic             sym_in,
  input  logic             sym_vld,
  input  logic             sync,
  output logic             a_out,
  output logic             a_vld,
  input  logic             a_rdy,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);
  localparam int IDX_W = $clog2(SYMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

  typedef enum logic {St0 = 1'b0, St1 = 1'b1} strength_e;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} fsm_e;

  // a=1 codeword: St0 on even indices, St1 on odd ones.
  function automatic logic [SYMS-1:0] pat_a1();
    logic [SYMS-1:0] p;
    for (int i = 0; i < SYMS; i++) p[i] = (i % 2 == 1) ? St1 : St0;
    return p;
  endfunction

  localparam logic [SYMS-1:0] PAT_A1 = pat_a1();
  localparam logic [SYMS-1:0] PAT_A0 = ~PAT_A1;

  fsm_e             fsm_q, fsm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SYMS-1:0]  curr_state_q, curr_state_d;
  logic             a_out_q, a_out_d;
  logic             a_vld_q, a_vld_d;
  logic             err_q, err_d;

  always_comb begin
    fsm_d        = fsm_q;
    idx_d        = idx_q;
    curr_state_d = curr_state_q;
    a_out_d      = a_out_q;
    a_vld_d      = a_vld_q;
    err_d        = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (sym_vld && sync) begin
          curr_state_d    = '0;
          curr_state_d[0] = sym_in;
          idx_d           = IDX_W'(1);
          fsm_d           = COLLECT;
        end
      end
      COLLECT: begin
        if (sym_vld && sync) begin
          err_d           = 1'b1;
          curr_state_d    = '0;
          curr_state_d[0] = sym_in;
          idx_d           = IDX_W'(1);
        end else if (sym_vld) begin
          curr_state_d[idx_q] = sym_in;
          if (idx_q == LAST_IDX) begin
            // Evaluate the frame including the symbol arriving this cycle.
            idx_d = '0;
            if (curr_state_d == PAT_A1) begin
              a_out_d = 1'b1;
              a_vld_d = 1'b1;
              fsm_d   = HOLD;
            end else if (curr_state_d == PAT_A0) begin
              a_out_d = 1'b0;
              a_vld_d = 1'b1;
              fsm_d   = HOLD;
            end else begin
              err_d = 1'b1;
              fsm_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (a_rdy) begin
          a_vld_d = 1'b0;
          if (sym_vld && sync) begin
            curr_state_d    = '0;
            curr_state_d[0] = sym_in;
            idx_d           = IDX_W'(1);
            fsm_d           = COLLECT;
          end else begin
            fsm_d = IDLE;
          end
        end else if (sym_vld) begin
          err_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      fsm_q        <= IDLE;
      idx_q        <= '0;
      curr_state_q <= '0;
      a_out_q      <= 1'b0;
      a_vld_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      idx_q        <= idx_d;
      curr_state_q <= curr_state_d;
      a_out_q      <= a_out_d;
      a_vld_q      <= a_vld_d;
      err_q        <= err_d;
    end
  end

  assign a_out = a_out_q;
  assign a_vld = a_vld_q;
  assign err   = err_q;
  assign busy  = (fsm_q != IDLE);

`ifdef MOS_STRENGTH_DEC_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Counts on err_d so the count moves on the same edge the pulse appears.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge c) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
